// File: rtl/xi_bus_frontend.sv
// XI host-side front end: synchronises async host strobes/address/data, sequences accesses,
// produces single-cycle write/read pulses, burst sub-address, data-bus enable and error flag.
module xi_bus_frontend #(
    parameter int unsigned XA_BITS     = 3,
    parameter int unsigned DW          = 8,
    parameter int unsigned XSUBA_MAX   = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           xi_wr_n,
    input  logic                           xi_rd_n,
    input  logic [XA_BITS-1:0]             xi_a,
    input  logic [DW-1:0]                  xi_d,
    output logic                           p_wr,
    output logic [XA_BITS-1:0]             p_wa,
    output logic [2**XA_BITS-1:0]          p_wsel,
    output logic [DW-1:0]                  p_d,
    output logic                           p_rd_start,
    output logic                           p_rd_finished,
    output logic [XA_BITS-1:0]             p_ra,
    output logic [$clog2(XSUBA_MAX+1)-1:0] p_rd_suba,
    output logic                           xi_d_oe,
    output logic                           p_err
);

    localparam int unsigned SubaW    = $clog2(XSUBA_MAX + 1);
    localparam int unsigned NumSel   = 2 ** XA_BITS;
    localparam int unsigned FlushCnt = SYNC_STAGES + 1;
    localparam int unsigned CntW     = $clog2(FlushCnt + 1);

    localparam logic [SubaW-1:0] SubaMax  = SubaW'(XSUBA_MAX);
    localparam logic [SubaW-1:0] SubaOne  = SubaW'(1);
    localparam logic [CntW-1:0]  FlushVal = CntW'(FlushCnt);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StWr,
        StRd
    } state_e;

    // Synchroniser chains, all the same depth so strobes, address and data stay aligned
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic [XA_BITS-1:0]     a_sync_q [SYNC_STAGES];
    logic [DW-1:0]          d_sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sync_q <= '1;
            rd_sync_q <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync_q[i] <= '0;
                d_sync_q[i] <= '0;
            end
        end else begin
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], xi_wr_n};
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], xi_rd_n};
            a_sync_q[0] <= xi_a;
            d_sync_q[0] <= xi_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync_q[i] <= a_sync_q[i-1];
                d_sync_q[i] <= d_sync_q[i-1];
            end
        end
    end

    // Edge-detect stage: cur is the synced level, prev is one cycle older
    logic               wr_cur_q, wr_prev_q, rd_cur_q, rd_prev_q;
    logic [XA_BITS-1:0] a_cur_q;
    logic [DW-1:0]      d_cur_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cur_q  <= 1'b1;
            wr_prev_q <= 1'b1;
            rd_cur_q  <= 1'b1;
            rd_prev_q <= 1'b1;
            a_cur_q   <= '0;
            d_cur_q   <= '0;
        end else begin
            wr_cur_q  <= wr_sync_q[SYNC_STAGES-1];
            wr_prev_q <= wr_cur_q;
            rd_cur_q  <= rd_sync_q[SYNC_STAGES-1];
            rd_prev_q <= rd_cur_q;
            a_cur_q   <= a_sync_q[SYNC_STAGES-1];
            d_cur_q   <= d_sync_q[SYNC_STAGES-1];
        end
    end

    logic wr_fall, rd_fall;
    assign wr_fall = wr_prev_q & ~wr_cur_q;
    assign rd_fall = rd_prev_q & ~rd_cur_q;

    state_e              state_q, state_d;
    logic [CntW-1:0]     arm_cnt_q, arm_cnt_d;
    logic                wr_q, wr_d;
    logic [XA_BITS-1:0]  wa_q, wa_d;
    logic [NumSel-1:0]   wsel_q, wsel_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                rd_start_q, rd_start_d;
    logic                rd_fin_q, rd_fin_d;
    logic [XA_BITS-1:0]  ra_q, ra_d;
    logic [SubaW-1:0]    suba_q, suba_d;
    logic                oe_q, oe_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StArm;
            arm_cnt_q  <= '0;
            wr_q       <= 1'b0;
            wa_q       <= '0;
            wsel_q     <= '0;
            wdata_q    <= '0;
            rd_start_q <= 1'b0;
            rd_fin_q   <= 1'b0;
            ra_q       <= '0;
            suba_q     <= '0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            wr_q       <= wr_d;
            wa_q       <= wa_d;
            wsel_q     <= wsel_d;
            wdata_q    <= wdata_d;
            rd_start_q <= rd_start_d;
            rd_fin_q   <= rd_fin_d;
            ra_q       <= ra_d;
            suba_q     <= suba_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        wr_d       = 1'b0;
        wa_d       = wa_q;
        wsel_d     = '0;
        wdata_d    = wdata_q;
        rd_start_d = 1'b0;
        rd_fin_d   = 1'b0;
        ra_d       = ra_q;
        suba_d     = suba_q;
        oe_d       = oe_q;
        err_d      = err_q;

        // Sub-address advances the cycle after the finish pulse
        if (rd_fin_q) begin
            suba_d = (suba_q == SubaMax) ? '0 : suba_q + SubaOne;
        end

        unique case (state_q)
            StArm: begin
                // Wait for the sync chain to flush its reset values before trusting the levels
                if (arm_cnt_q != FlushVal) begin
                    arm_cnt_d = arm_cnt_q + CntOne;
                end else if (wr_cur_q && rd_cur_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (wr_fall && rd_cur_q) begin
                    wr_d          = 1'b1;
                    wa_d          = a_cur_q;
                    wsel_d[a_cur_q] = 1'b1;
                    wdata_d       = d_cur_q;
                    suba_d        = '0;
                    state_d       = StWr;
                end else if (rd_fall && wr_cur_q) begin
                    ra_d       = a_cur_q;
                    rd_start_d = 1'b1;
                    oe_d       = 1'b1;
                    state_d    = StRd;
                end else if (wr_fall || rd_fall) begin
                    err_d   = 1'b1;
                    state_d = StArm;
                end
            end
            StWr: begin
                if (rd_fall) begin
                    err_d = 1'b1;
                end
                if (wr_cur_q) begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                if (wr_fall) begin
                    err_d = 1'b1;
                end
                if (rd_cur_q) begin
                    rd_fin_d = 1'b1;
                    oe_d     = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StArm;
        endcase
    end

    assign p_wr          = wr_q;
    assign p_wa          = wa_q;
    assign p_wsel        = wsel_q;
    assign p_d           = wdata_q;
    assign p_rd_start    = rd_start_q;
    assign p_rd_finished = rd_fin_q;
    assign p_ra          = ra_q;
    assign p_rd_suba     = suba_q;
    assign xi_d_oe       = oe_q;
    assign p_err         = err_q;

endmodule

// File: tb/tb_xi_bus_frontend.sv
// Self-checking bench for xi_bus_frontend: scenario tasks plus randomized accesses checked
// against latency arithmetic and an integer sub-address model.
module tb_xi_bus_frontend;

    localparam int S = 2;

    logic       clk, rst, xi_wr_n, xi_rd_n;
    logic [2:0] xi_a;
    logic [7:0] xi_d;
    logic       p_wr, p_rd_start, p_rd_finished, xi_d_oe, p_err;
    logic [2:0] p_wa, p_ra, p_rd_suba;
    logic [7:0] p_wsel, p_d;

    xi_bus_frontend #(
        .XA_BITS    (3),
        .DW         (8),
        .XSUBA_MAX  (7),
        .SYNC_STAGES(S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .xi_wr_n      (xi_wr_n),
        .xi_rd_n      (xi_rd_n),
        .xi_a         (xi_a),
        .xi_d         (xi_d),
        .p_wr         (p_wr),
        .p_wa         (p_wa),
        .p_wsel       (p_wsel),
        .p_d          (p_d),
        .p_rd_start   (p_rd_start),
        .p_rd_finished(p_rd_finished),
        .p_ra         (p_ra),
        .p_rd_suba    (p_rd_suba),
        .xi_d_oe      (xi_d_oe),
        .p_err        (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int model_suba = 0;

    // Observations gathered while an access runs
    int n_edge, m_edge;
    int wr_cnt, wr_first, wr_last, st_cnt, st_cyc, fin_cnt, fin_cyc, oe_cnt, oe_first, wsel_bad;
    logic [2:0] wa_seen, ra_seen, suba_at_st, suba_late;
    logic [7:0] wsel_seen, d_seen;

    task automatic clear_obs();
        wr_cnt = 0; wr_first = -1; wr_last = -1; st_cnt = 0; st_cyc = -1;
        fin_cnt = 0; fin_cyc = -1; oe_cnt = 0; oe_first = -1; wsel_bad = 0;
        suba_late = 'x; suba_at_st = 'x; m_edge = -100;
    endtask

    task automatic step();
        @(negedge clk);
        if (p_wr) begin
            wr_cnt++;
            wr_last = cyc;
            if (wr_first < 0) begin
                wr_first = cyc; wa_seen = p_wa; wsel_seen = p_wsel; d_seen = p_d;
            end
        end else if (p_wsel != 8'h00) begin
            wsel_bad++;
        end
        if (p_rd_start) begin
            st_cnt++; st_cyc = cyc; suba_at_st = p_rd_suba; ra_seen = p_ra;
        end
        if (p_rd_finished) begin
            fin_cnt++; fin_cyc = cyc;
        end
        if (xi_d_oe) begin
            oe_cnt++;
            if (oe_first < 0) oe_first = cyc;
        end
        if (cyc == m_edge + S + 2) suba_late = p_rd_suba;
    endtask

    task automatic do_access(input bit is_wr, input logic [2:0] a, input logic [7:0] d,
                             input int low_len, input int high_len);
        clear_obs();
        step();
        xi_a = a;
        xi_d = d;
        step();
        if (is_wr) xi_wr_n = 1'b0;
        else xi_rd_n = 1'b0;
        n_edge = cyc + 1;
        repeat (low_len) step();
        xi_wr_n = 1'b1;
        xi_rd_n = 1'b1;
        m_edge = cyc + 1;
        repeat (high_len) step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (S + 4) @(negedge clk);
        model_suba = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (p_wr !== 1'b0) begin bad++; $display("FAIL rst_p_wr: got %b want 0", p_wr); end
        total++; if (p_wa !== 3'd0) begin bad++; $display("FAIL rst_p_wa: got %0d want 0", p_wa); end
        total++; if (p_wsel !== 8'h00) begin bad++; $display("FAIL rst_p_wsel: got %h want 00", p_wsel); end
        total++; if (p_d !== 8'h00) begin bad++; $display("FAIL rst_p_d: got %h want 00", p_d); end
        total++; if (p_rd_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", p_rd_start); end
        total++; if (p_rd_finished !== 1'b0) begin bad++; $display("FAIL rst_fin: got %b want 0", p_rd_finished); end
        total++; if (p_ra !== 3'd0) begin bad++; $display("FAIL rst_p_ra: got %0d want 0", p_ra); end
        total++; if (p_rd_suba !== 3'd0) begin bad++; $display("FAIL rst_suba: got %0d want 0", p_rd_suba); end
        total++; if (xi_d_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", xi_d_oe); end
        total++; if (p_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", p_err); end
        rst = 1'b0;
        repeat (S + 4) @(negedge clk);
        model_suba = 0;
    endtask

    task automatic test_single_write();
        do_access(1'b1, 3'd5, 8'hA5, 6, 8);
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL sw_count: got %0d want 1", wr_cnt); end
        total++; if (wr_first !== n_edge + S + 1) begin bad++; $display("FAIL sw_latency: got %0d want %0d", wr_first, n_edge + S + 1); end
        total++; if (wa_seen !== 3'd5) begin bad++; $display("FAIL sw_wa: got %0d want 5", wa_seen); end
        total++; if (wsel_seen !== 8'b0010_0000) begin bad++; $display("FAIL sw_wsel: got %b want 00100000", wsel_seen); end
        total++; if (d_seen !== 8'hA5) begin bad++; $display("FAIL sw_d: got %h want a5", d_seen); end
        total++; if (wsel_bad !== 0) begin bad++; $display("FAIL sw_wsel_idle: got %0d want 0", wsel_bad); end
        total++; if (p_rd_suba !== 3'd0) begin bad++; $display("FAIL sw_suba: got %0d want 0", p_rd_suba); end
        total++; if (p_wa !== 3'd5 || p_d !== 8'hA5) begin bad++; $display("FAIL sw_hold: got %0d/%h want 5/a5", p_wa, p_d); end
        model_suba = 0;
    endtask

    task automatic test_burst_read();
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            int lo;
            lo = 2 + (k % 4);
            do_access(1'b0, 3'd2, 8'h00, lo, 7);
            total++; if (st_cnt !== 1 || st_cyc !== n_edge + S + 1) begin bad++; $display("FAIL br_start[%0d]: got n=%0d at %0d want 1 at %0d", k, st_cnt, st_cyc, n_edge + S + 1); end
            total++; if (fin_cnt !== 1 || fin_cyc !== m_edge + S + 1) begin bad++; $display("FAIL br_fin[%0d]: got n=%0d at %0d want 1 at %0d", k, fin_cnt, fin_cyc, m_edge + S + 1); end
            total++; if (oe_cnt !== m_edge - n_edge || oe_first !== n_edge + S + 1) begin bad++; $display("FAIL br_oe[%0d]: got %0d from %0d want %0d from %0d", k, oe_cnt, oe_first, m_edge - n_edge, n_edge + S + 1); end
            total++; if (suba_at_st !== 3'(k % 8)) begin bad++; $display("FAIL br_suba[%0d]: got %0d want %0d", k, suba_at_st, k % 8); end
            total++; if (suba_late !== 3'((k + 1) % 8)) begin bad++; $display("FAIL br_suba_next[%0d]: got %0d want %0d", k, suba_late, (k + 1) % 8); end
            total++; if (ra_seen !== 3'd2) begin bad++; $display("FAIL br_ra[%0d]: got %0d want 2", k, ra_seen); end
        end
        model_suba = 9 % 8;
    endtask

    task automatic test_write_clears();
        for (int k = 0; k < 3; k++) begin
            do_access(1'b0, 3'd7, 8'h00, 3, 7);
            total++; if (suba_at_st !== 3'(model_suba)) begin bad++; $display("FAIL wc_suba[%0d]: got %0d want %0d", k, suba_at_st, model_suba); end
            model_suba = (model_suba + 1) % 8;
        end
        do_access(1'b1, 3'd1, 8'h5A, 3, 7);
        model_suba = 0;
        total++; if (p_rd_suba !== 3'd0) begin bad++; $display("FAIL wc_after_wr: got %0d want 0", p_rd_suba); end
        do_access(1'b0, 3'd7, 8'h00, 3, 7);
        total++; if (suba_at_st !== 3'd0) begin bad++; $display("FAIL wc_final: got %0d want 0", suba_at_st); end
        model_suba = 1;
    endtask

    task automatic test_back_to_back();
        // Two writes to the same register separated by a single high sample
        clear_obs();
        step();
        xi_a = 3'd6;
        xi_d = 8'hC3;
        step();
        xi_wr_n = 1'b0;
        n_edge = cyc + 1;
        repeat (3) step();
        xi_wr_n = 1'b1;
        step();
        xi_wr_n = 1'b0;
        m_edge = cyc + 1;
        repeat (3) step();
        xi_wr_n = 1'b1;
        repeat (7) step();
        total++; if (wr_cnt !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", wr_cnt); end
        total++; if (wr_last !== m_edge + S + 1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", wr_last, m_edge + S + 1); end
        total++; if (p_d !== 8'hC3 || p_err !== 1'b0) begin bad++; $display("FAIL b2b_data: got %h err=%b want c3 err=0", p_d, p_err); end
        model_suba = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            bit         is_wr;
            logic [2:0] a;
            logic [7:0] d, ew;
            int         lo;
            is_wr = 1'($urandom_range(0, 1));
            a     = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            lo    = $urandom_range(1, 6);
            do_access(is_wr, a, d, lo, $urandom_range(S + 4, S + 7));
            if (is_wr) begin
                ew = 8'h01 << a;
                model_suba = 0;
                total++; if (wr_cnt !== 1 || wr_first !== n_edge + S + 1) begin bad++; $display("FAIL rnd_wr[%0d]: got n=%0d at %0d want 1 at %0d", k, wr_cnt, wr_first, n_edge + S + 1); end
                total++; if (wa_seen !== a || d_seen !== d || wsel_seen !== ew) begin bad++; $display("FAIL rnd_wdata[%0d]: got %0d/%h/%b want %0d/%h/%b", k, wa_seen, d_seen, wsel_seen, a, d, ew); end
                total++; if (p_rd_suba !== 3'd0 || st_cnt !== 0) begin bad++; $display("FAIL rnd_wside[%0d]: got suba=%0d st=%0d want 0/0", k, p_rd_suba, st_cnt); end
            end else begin
                total++; if (st_cnt !== 1 || st_cyc !== n_edge + S + 1 || ra_seen !== a) begin bad++; $display("FAIL rnd_start[%0d]: got n=%0d at %0d ra=%0d want 1 at %0d ra=%0d", k, st_cnt, st_cyc, ra_seen, n_edge + S + 1, a); end
                total++; if (fin_cnt !== 1 || fin_cyc !== m_edge + S + 1) begin bad++; $display("FAIL rnd_fin[%0d]: got n=%0d at %0d want 1 at %0d", k, fin_cnt, fin_cyc, m_edge + S + 1); end
                total++; if (oe_cnt !== lo || oe_first !== n_edge + S + 1) begin bad++; $display("FAIL rnd_oe[%0d]: got %0d from %0d want %0d from %0d", k, oe_cnt, oe_first, lo, n_edge + S + 1); end
                total++; if (suba_at_st !== 3'(model_suba)) begin bad++; $display("FAIL rnd_suba[%0d]: got %0d want %0d", k, suba_at_st, model_suba); end
                model_suba = (model_suba + 1) % 8;
                total++; if (suba_late !== 3'(model_suba) || wr_cnt !== 0) begin bad++; $display("FAIL rnd_next[%0d]: got %0d wr=%0d want %0d wr=0", k, suba_late, wr_cnt, model_suba); end
            end
        end
        total++; if (p_err !== 1'b0) begin bad++; $display("FAIL rnd_err: got %b want 0", p_err); end
    endtask

    task automatic test_overlap_rd_in_wr();
        clear_obs();
        step();
        xi_a = 3'd3;
        xi_d = 8'h77;
        step();
        xi_wr_n = 1'b0;
        repeat (4) step();
        xi_rd_n = 1'b0;
        repeat (4) step();
        xi_rd_n = 1'b1;
        repeat (2) step();
        xi_wr_n = 1'b1;
        repeat (7) step();
        total++; if (p_err !== 1'b1) begin bad++; $display("FAIL ov_err: got %b want 1", p_err); end
        total++; if (wr_cnt !== 1) begin bad++; $display("FAIL ov_wr: got %0d want 1", wr_cnt); end
        total++; if (st_cnt !== 0 || oe_cnt !== 0) begin bad++; $display("FAIL ov_read: got st=%0d oe=%0d want 0/0", st_cnt, oe_cnt); end
    endtask

    task automatic test_both_same();
        clear_obs();
        step();
        xi_wr_n = 1'b0;
        xi_rd_n = 1'b0;
        repeat (5) step();
        xi_wr_n = 1'b1;
        xi_rd_n = 1'b1;
        repeat (7) step();
        total++; if (p_err !== 1'b1) begin bad++; $display("FAIL both_err: got %b want 1", p_err); end
        total++; if (wr_cnt !== 0 || st_cnt !== 0 || oe_cnt !== 0) begin bad++; $display("FAIL both_access: got wr=%0d st=%0d oe=%0d want 0/0/0", wr_cnt, st_cnt, oe_cnt); end
        do_access(1'b1, 3'd4, 8'h96, 3, 7);
        model_suba = 0;
        total++; if (wr_cnt !== 1 || wa_seen !== 3'd4 || d_seen !== 8'h96) begin bad++; $display("FAIL both_recover: got n=%0d %0d/%h want 1 4/96", wr_cnt, wa_seen, d_seen); end
    endtask

    task automatic test_reset_strobe_low();
        @(negedge clk);
        xi_a = 3'd3;
        xi_d = 8'h3C;
        xi_wr_n = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_suba = 0;
        clear_obs();
        repeat (12) step();
        total++; if (wr_cnt !== 0 || st_cnt !== 0) begin bad++; $display("FAIL rsl_spurious: got wr=%0d st=%0d want 0/0", wr_cnt, st_cnt); end
        xi_wr_n = 1'b1;
        repeat (5) step();
        total++; if (wr_cnt !== 0 || p_err !== 1'b0) begin bad++; $display("FAIL rsl_rise: got wr=%0d err=%b want 0/0", wr_cnt, p_err); end
        do_access(1'b1, 3'd3, 8'h3C, 4, 7);
        total++; if (wr_cnt !== 1 || wr_first !== n_edge + S + 1) begin bad++; $display("FAIL rsl_next: got n=%0d at %0d want 1 at %0d", wr_cnt, wr_first, n_edge + S + 1); end
        total++; if (wa_seen !== 3'd3 || d_seen !== 8'h3C || wsel_seen !== 8'b0000_1000) begin bad++; $display("FAIL rsl_data: got %0d/%h/%b want 3/3c/00001000", wa_seen, d_seen, wsel_seen); end
    endtask

    task automatic test_reset_mid_read();
        do_access(1'b0, 3'd6, 8'h00, 2, 7);
        do_access(1'b0, 3'd6, 8'h00, 2, 7);
        clear_obs();
        step();
        xi_a = 3'd6;
        step();
        xi_rd_n = 1'b0;
        repeat (S + 4) step();
        total++; if (xi_d_oe !== 1'b1 || p_ra !== 3'd6) begin bad++; $display("FAIL rmr_active: got oe=%b ra=%0d want 1/6", xi_d_oe, p_ra); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (xi_d_oe !== 1'b0 || p_ra !== 3'd0 || p_rd_suba !== 3'd0) begin bad++; $display("FAIL rmr_clear_rd: got oe=%b ra=%0d suba=%0d want 0/0/0", xi_d_oe, p_ra, p_rd_suba); end
        total++; if (p_wa !== 3'd0 || p_d !== 8'h00 || p_wr !== 1'b0 || p_err !== 1'b0) begin bad++; $display("FAIL rmr_clear_wr: got wa=%0d d=%h wr=%b err=%b want 0", p_wa, p_d, p_wr, p_err); end
        rst = 1'b0;
        model_suba = 0;
        repeat (2) @(negedge clk);
        xi_rd_n = 1'b1;
        clear_obs();
        repeat (10) step();
        total++; if (fin_cnt !== 0 || oe_cnt !== 0 || st_cnt !== 0) begin bad++; $display("FAIL rmr_no_finish: got fin=%0d oe=%0d st=%0d want 0/0/0", fin_cnt, oe_cnt, st_cnt); end
    endtask

    initial begin
        rst     = 1'b1;
        xi_wr_n = 1'b1;
        xi_rd_n = 1'b1;
        xi_a    = '0;
        xi_d    = '0;
        test_reset();
        test_single_write();
        test_burst_read();
        test_write_clears();
        test_back_to_back();
        test_random();
        test_overlap_rd_in_wr();
        apply_reset();
        test_both_same();
        test_reset_strobe_low();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
